// File: rtl/regfile8x16_sb_if.sv
// rtl/regfile8x16_sb_if.sv - decode/write-back bundle for the 8x16 register file with scoreboard
interface regfile8x16_sb_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [2:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             rsv_en;
  logic [2:0]       rsv_sel;
  logic             chk_en;
  logic [2:0]       chk_sel;
  logic             err_clr;
  logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]       busy;
  logic             hazard;
  logic             rsv_full;
  logic             err;

  modport master (
    output wr_en, wr_sel, wr_data, rsv_en, rsv_sel, chk_en, chk_sel, err_clr,
    input  q0, q1, q2, q3, q4, q5, q6, q7, busy, hazard, rsv_full, err
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rsv_en, rsv_sel, chk_en, chk_sel, err_clr,
    output q0, q1, q2, q3, q4, q5, q6, q7, busy, hazard, rsv_full, err
  );
endinterface

// File: rtl/regfile8x16_sb.sv
// rtl/regfile8x16_sb.sv - 8x16 register file with per-register pending-write scoreboard
module regfile8x16_sb #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int PENDW = 2
) (
  input logic           CLK,
  input logic           RSTN,
  regfile8x16_sb_if.slave bus
);
  localparam logic [PENDW-1:0] PMAX = '1;
  localparam logic [PENDW-1:0] PONE = PENDW'(1);

  logic [WIDTH-1:0] regs     [NREG];
  logic [PENDW-1:0] pend     [NREG];
  logic [PENDW-1:0] pend_nxt [NREG];
  logic             err_set;

  // Next pending count per register and protocol-violation detection.
  // A same-index reserve and write cancel; at saturation the write still
  // drains one slot and the dropped reservation is not counted as an error.
  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt[i] = pend[i];
      if (bus.rsv_en && bus.rsv_sel == 3'(i) && bus.wr_en && bus.wr_sel == 3'(i)) begin
        if (pend[i] == PMAX) pend_nxt[i] = pend[i] - PONE;
      end else if (bus.rsv_en && bus.rsv_sel == 3'(i)) begin
        if (pend[i] == PMAX) err_set = 1'b1;
        else                 pend_nxt[i] = pend[i] + PONE;
      end else if (bus.wr_en && bus.wr_sel == 3'(i)) begin
        if (pend[i] == '0) err_set = 1'b1;
        else               pend_nxt[i] = pend[i] - PONE;
      end
    end
  end

  // Register storage, scoreboard counters and sticky error flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      bus.err <= 1'b0;
    end else begin
      if (bus.wr_en) regs[bus.wr_sel] <= bus.wr_data;
      for (int i = 0; i < NREG; i++) pend[i] <= pend_nxt[i];
      bus.err <= err_set | (bus.err & ~bus.err_clr);
    end
  end

  // Busy flags come only from registered counters, so hazard drops one
  // cycle after the last write, when q already carries the new value.
  always_comb begin
    for (int i = 0; i < 8; i++) bus.busy[i] = (pend[i] != '0);
  end

  assign bus.hazard   = bus.chk_en & bus.busy[bus.chk_sel];
  assign bus.rsv_full = (pend[bus.rsv_sel] == PMAX);

  assign bus.q0 = regs[0];
  assign bus.q1 = regs[1];
  assign bus.q2 = regs[2];
  assign bus.q3 = regs[3];
  assign bus.q4 = regs[4];
  assign bus.q5 = regs[5];
  assign bus.q6 = regs[6];
  assign bus.q7 = regs[7];
endmodule

// File: tb/tb_regfile8x16_sb.sv
// tb/tb_regfile8x16_sb.sv - scoreboard bench for regfile8x16_sb
module tb_regfile8x16_sb;
  logic CLK;
  logic RSTN;

  regfile8x16_sb_if #(.WIDTH(16)) ifc ();

  regfile8x16_sb dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [127:0] q;
    logic [7:0]   busy;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        re;
    logic [2:0]  rs;
    logic        ce;
    logic [2:0]  cs;
    logic        ec;
    logic        hz;
    logic        fl;
  } step_t;

  exp_t        sb[$];
  logic [15:0] m_reg  [8];
  logic [1:0]  m_pend [8];
  logic        m_err;
  logic [127:0] last_q;
  int nvec  = 0;
  int nfail = 0;

  function automatic logic [127:0] dut_q();
    return {ifc.q7, ifc.q6, ifc.q5, ifc.q4, ifc.q3, ifc.q2, ifc.q1, ifc.q0};
  endfunction

  function automatic step_t mk(logic we, logic [2:0] ws, logic [15:0] wd, logic re, logic [2:0] rs,
                               logic ce, logic [2:0] cs, logic ec, logic hz, logic fl);
    step_t s;
    s = '{we: we, ws: ws, wd: wd, re: re, rs: rs, ce: ce, cs: cs, ec: ec, hz: hz, fl: fl};
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = '0;
    end
    m_err  = 1'b0;
    last_q = '0;
    sb.delete();
  endtask

  task automatic idle();
    ifc.wr_en = 0; ifc.wr_sel = 0; ifc.wr_data = 0; ifc.rsv_en = 0; ifc.rsv_sel = 0;
    ifc.chk_en = 0; ifc.chk_sel = 0; ifc.err_clr = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Apply one cycle of stimulus and push the state expected after the edge.
  task automatic drive(input step_t s);
    exp_t e;
    logic set, inc, dec;
    logic [1:0] np;
    ifc.wr_en = s.we; ifc.wr_sel = s.ws; ifc.wr_data = s.wd;
    ifc.rsv_en = s.re; ifc.rsv_sel = s.rs;
    ifc.chk_en = s.ce; ifc.chk_sel = s.cs; ifc.err_clr = s.ec;
    set = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inc = s.re && (s.rs == 3'(i));
      dec = s.we && (s.ws == 3'(i));
      np  = m_pend[i];
      if (inc && dec)  np = (m_pend[i] == 2'd3) ? 2'd2 : m_pend[i];
      else if (inc)    begin if (m_pend[i] == 2'd3) set = 1'b1; else np = m_pend[i] + 2'd1; end
      else if (dec)    begin if (m_pend[i] == 2'd0) set = 1'b1; else np = m_pend[i] - 2'd1; end
      m_pend[i] = np;
    end
    if (s.we) m_reg[s.ws] = s.wd;
    m_err = set | (m_err & ~s.ec);
    for (int i = 0; i < 8; i++) begin
      e.q[i*16 +: 16] = m_reg[i];
      e.busy[i]       = (m_pend[i] != 2'd0);
    end
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifc.wr_en = 1'($urandom); ifc.wr_sel = 3'($urandom); ifc.wr_data = 16'($urandom);
      ifc.rsv_en = 1'($urandom); ifc.rsv_sel = 3'($urandom); ifc.chk_en = 1'b1;
      ifc.chk_sel = 3'($urandom); ifc.err_clr = 1'($urandom);
      #5;
    end
    nvec++; if (dut_q() !== 128'd0) begin nfail++; $display("FAIL reset_q got %h want 0", dut_q()); end
    nvec++; if (ifc.busy !== 8'h00) begin nfail++; $display("FAIL reset_busy got %h want 00", ifc.busy); end
    nvec++; if (ifc.err !== 1'b0) begin nfail++; $display("FAIL reset_err got %b want 0", ifc.err); end
    nvec++; if (ifc.hazard !== 1'b0) begin nfail++; $display("FAIL reset_hazard got %b want 0", ifc.hazard); end
    idle();
    model_reset();
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    step_t st[$];
    exp_t e;
    st.push_back(mk(0, 0, 16'h0000, 1, 5, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(1, 5, 16'hA5C3, 0, 0, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(1, 0, 16'h1111, 1, 1, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(1, 1, 16'h2222, 0, 0, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(1, 1, 16'h3333, 0, 0, 0, 0, 0, 1'bx, 1'bx));
    foreach (st[k]) begin
      drive(st[k]);
      #1;
      nvec++; if (dut_q() !== last_q) begin nfail++; $display("FAIL write_nobypass step %0d got %h want %h", k, dut_q(), last_q); end
      tick();
      e = sb.pop_front();
      nvec++; if (dut_q() !== e.q) begin nfail++; $display("FAIL write_q step %0d got %h want %h", k, dut_q(), e.q); end
      nvec++; if (ifc.busy !== e.busy) begin nfail++; $display("FAIL write_busy step %0d got %h want %h", k, ifc.busy, e.busy); end
      nvec++; if (ifc.err !== e.err) begin nfail++; $display("FAIL write_err step %0d got %b want %b", k, ifc.err, e.err); end
      last_q = e.q;
    end
  endtask

  task automatic test_hazard();
    step_t st[$];
    exp_t e;
    st.push_back(mk(0, 0, 16'h0000, 1, 2, 1, 2, 0, 1'b0, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 2, 0, 1'b1, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 3, 0, 1'b0, 1'bx));
    st.push_back(mk(1, 2, 16'h1234, 0, 0, 1, 2, 0, 1'b1, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 2, 0, 1'b0, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 1, 6, 0, 6, 0, 1'b0, 1'bx));
    foreach (st[k]) begin
      drive(st[k]);
      #1;
      nvec++; if (dut_q() !== last_q) begin nfail++; $display("FAIL hazard_nobypass step %0d got %h want %h", k, dut_q(), last_q); end
      if (st[k].hz !== 1'bx) begin
        nvec++; if (ifc.hazard !== st[k].hz) begin nfail++; $display("FAIL hazard step %0d got %b want %b", k, ifc.hazard, st[k].hz); end
      end
      tick();
      e = sb.pop_front();
      nvec++; if (dut_q() !== e.q) begin nfail++; $display("FAIL hazard_q step %0d got %h want %h", k, dut_q(), e.q); end
      nvec++; if (ifc.busy !== e.busy) begin nfail++; $display("FAIL hazard_busy step %0d got %h want %h", k, ifc.busy, e.busy); end
      nvec++; if (ifc.err !== e.err) begin nfail++; $display("FAIL hazard_err step %0d got %b want %b", k, ifc.err, e.err); end
      last_q = e.q;
    end
    idle();
    ifc.wr_en = 1'b1; ifc.wr_sel = 3'd6;
    drive(mk(1, 6, 16'h0606, 0, 0, 0, 0, 0, 1'bx, 1'bx));
    tick();
    e = sb.pop_front();
    last_q = e.q;
  endtask

  task automatic test_saturation();
    step_t st[$];
    exp_t e;
    st.push_back(mk(0, 0, 16'h0000, 1, 7, 0, 0, 0, 1'bx, 1'b0));
    st.push_back(mk(0, 0, 16'h0000, 1, 7, 0, 0, 0, 1'bx, 1'b0));
    st.push_back(mk(0, 0, 16'h0000, 1, 7, 0, 0, 0, 1'bx, 1'b0));
    st.push_back(mk(0, 0, 16'h0000, 0, 7, 1, 7, 0, 1'b1, 1'b1));
    st.push_back(mk(0, 0, 16'h0000, 1, 7, 0, 0, 0, 1'bx, 1'b1));
    st.push_back(mk(1, 7, 16'h7777, 1, 7, 0, 0, 0, 1'bx, 1'b1));
    st.push_back(mk(0, 0, 16'h0000, 0, 7, 0, 0, 1, 1'bx, 1'b0));
    st.push_back(mk(1, 7, 16'h7778, 1, 7, 0, 0, 0, 1'bx, 1'b0));
    foreach (st[k]) begin
      drive(st[k]);
      #1;
      nvec++; if (dut_q() !== last_q) begin nfail++; $display("FAIL sat_nobypass step %0d got %h want %h", k, dut_q(), last_q); end
      if (st[k].hz !== 1'bx) begin
        nvec++; if (ifc.hazard !== st[k].hz) begin nfail++; $display("FAIL sat_hazard step %0d got %b want %b", k, ifc.hazard, st[k].hz); end
      end
      if (st[k].fl !== 1'bx) begin
        nvec++; if (ifc.rsv_full !== st[k].fl) begin nfail++; $display("FAIL sat_rsv_full step %0d got %b want %b", k, ifc.rsv_full, st[k].fl); end
      end
      tick();
      e = sb.pop_front();
      nvec++; if (dut_q() !== e.q) begin nfail++; $display("FAIL sat_q step %0d got %h want %h", k, dut_q(), e.q); end
      nvec++; if (ifc.busy !== e.busy) begin nfail++; $display("FAIL sat_busy step %0d got %h want %h", k, ifc.busy, e.busy); end
      nvec++; if (ifc.err !== e.err) begin nfail++; $display("FAIL sat_err step %0d got %b want %b", k, ifc.err, e.err); end
      last_q = e.q;
    end
  endtask

  task automatic test_underflow();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1, 1, 16'hC0DE, 0, 0, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1'bx, 1'bx));
    st.push_back(mk(1, 4, 16'h4444, 0, 0, 0, 0, 1, 1'bx, 1'bx));
    st.push_back(mk(1, 3, 16'h3030, 1, 3, 0, 0, 1, 1'bx, 1'b0));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 3, 0, 1'b0, 1'bx));
    foreach (st[k]) begin
      drive(st[k]);
      #1;
      nvec++; if (dut_q() !== last_q) begin nfail++; $display("FAIL under_nobypass step %0d got %h want %h", k, dut_q(), last_q); end
      if (st[k].hz !== 1'bx) begin
        nvec++; if (ifc.hazard !== st[k].hz) begin nfail++; $display("FAIL under_hazard step %0d got %b want %b", k, ifc.hazard, st[k].hz); end
      end
      if (st[k].fl !== 1'bx) begin
        nvec++; if (ifc.rsv_full !== st[k].fl) begin nfail++; $display("FAIL under_rsv_full step %0d got %b want %b", k, ifc.rsv_full, st[k].fl); end
      end
      tick();
      e = sb.pop_front();
      nvec++; if (dut_q() !== e.q) begin nfail++; $display("FAIL under_q step %0d got %h want %h", k, dut_q(), e.q); end
      nvec++; if (ifc.busy !== e.busy) begin nfail++; $display("FAIL under_busy step %0d got %h want %h", k, ifc.busy, e.busy); end
      nvec++; if (ifc.err !== e.err) begin nfail++; $display("FAIL under_err step %0d got %b want %b", k, ifc.err, e.err); end
      last_q = e.q;
    end
  endtask

  task automatic test_async_reset();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1, 3, 16'h5A5A, 0, 0, 0, 0, 0, 1'bx, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 1, 3, 0, 0, 1, 1'bx, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 1, 3, 0, 0, 0, 1'bx, 1'bx));
    foreach (st[k]) begin
      drive(st[k]);
      tick();
      e = sb.pop_front();
      nvec++; if (dut_q() !== e.q) begin nfail++; $display("FAIL arst_pre_q step %0d got %h want %h", k, dut_q(), e.q); end
      nvec++; if (ifc.busy !== e.busy) begin nfail++; $display("FAIL arst_pre_busy step %0d got %h want %h", k, ifc.busy, e.busy); end
    end
    idle();
    #2;
    RSTN = 1'b0;
    #1;
    nvec++; if (ifc.q3 !== 16'h0000) begin nfail++; $display("FAIL arst_q3 got %h want 0000", ifc.q3); end
    nvec++; if (dut_q() !== 128'd0) begin nfail++; $display("FAIL arst_q got %h want 0", dut_q()); end
    nvec++; if (ifc.busy !== 8'h00) begin nfail++; $display("FAIL arst_busy got %h want 00", ifc.busy); end
    nvec++; if (ifc.err !== 1'b0) begin nfail++; $display("FAIL arst_err got %b want 0", ifc.err); end
    #1;
    RSTN = 1'b1;
    model_reset();
    tick();
    st.delete();
    st.push_back(mk(0, 0, 16'h0000, 1, 3, 1, 3, 0, 1'b0, 1'b0));
    st.push_back(mk(1, 3, 16'hBEEF, 0, 0, 1, 3, 0, 1'b1, 1'bx));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 3, 0, 1'b0, 1'bx));
    foreach (st[k]) begin
      drive(st[k]);
      #1;
      nvec++; if (dut_q() !== last_q) begin nfail++; $display("FAIL resume_nobypass step %0d got %h want %h", k, dut_q(), last_q); end
      if (st[k].hz !== 1'bx) begin
        nvec++; if (ifc.hazard !== st[k].hz) begin nfail++; $display("FAIL resume_hazard step %0d got %b want %b", k, ifc.hazard, st[k].hz); end
      end
      tick();
      e = sb.pop_front();
      nvec++; if (dut_q() !== e.q) begin nfail++; $display("FAIL resume_q step %0d got %h want %h", k, dut_q(), e.q); end
      nvec++; if (ifc.busy !== e.busy) begin nfail++; $display("FAIL resume_busy step %0d got %h want %h", k, ifc.busy, e.busy); end
      nvec++; if (ifc.err !== e.err) begin nfail++; $display("FAIL resume_err step %0d got %b want %b", k, ifc.err, e.err); end
      last_q = e.q;
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_basic_write();
    test_hazard();
    test_saturation();
    test_underflow();
    test_async_reset();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
